load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Executes the data-memory side of the decoded MemRead/MemWrite controls for RV32IM loads/stores.
//  Accepts one request at a time from execute: funct3, ALU-computed address, rs2 data and rd.
//  Drives a valid/ready word bus to data memory and returns formatted load data for writeback.
//  Holds stall high while busy; reports misaligned or illegal accesses without touching the bus.
// PARAMETERS
//  TIMEOUT_CYC  255  bus_ready wait limit in cycles (used only with LSU_TIMEOUT_EN)
// PORTS
//  clk        in   1   core clock, single clock domain
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   execute presents a memory request
//  req_ready  out  1   LSU can accept; equals (state==IDLE)
//  mem_read   in   1   MemRead control
//  mem_write  in   1   MemWrite control
//  funct3     in   3   access size/sign: LB/LH/LW/LBU/LHU, SB/SH/SW
//  addr       in   32  byte address from ALU
//  wdata      in   32  store data (rs2)
//  rd         in   5   load destination register
//  bus_valid  out  1   bus request
//  bus_we     out  1   1=write, 0=read
//  bus_addr   out  32  word-aligned address, {addr[31:2],2'b00}
//  bus_wdata  out  32  lane-steered store data
//  bus_wstrb  out  4   byte enables; 4'b0000 on reads
//  bus_ready  in   1   memory accepts/completes the request this cycle
//  bus_rdata  in   32  read word, valid when bus_valid&bus_ready&!bus_we
//  rsp_valid  out  1   one-cycle completion pulse
//  rsp_wen    out  1   write rsp_data to rsp_rd (loads only, never on error)
//  rsp_rd     out  5   destination register
//  rsp_data   out  32  extended load data; 0 for stores/errors
//  rsp_err    out  1   misaligned/illegal/timeout
//  stall      out  1   (state!=IDLE); freezes upstream pipeline
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs 0; bus_valid drops asynchronously.
//  States: IDLE, BUS, DONE, ERR.
//  IDLE: on req_valid & (mem_read|mem_write): latch all request fields.
//   Illegal -> ERR: both mem_read and mem_write set; load funct3 in {011,110,111}; store funct3>=011.
//   Misaligned -> ERR: half with addr[0]=1; word with addr[1:0]!=0.
//   Otherwise -> BUS. req_valid with neither control set is ignored.
//  BUS: bus_valid=1; bus_* held stable until bus_ready. On bus_ready: capture formatted
//   rdata for loads, -> DONE.
//  DONE: rsp_valid=1, rsp_wen=load, rsp_err=0, -> IDLE.
//  ERR: rsp_valid=1, rsp_err=1, rsp_wen=0, no bus activity, -> IDLE.
//  Latency: accept at T; bus_valid at T+1; if bus_ready at T+1, rsp_valid at T+2.
//   Error response at T+1. Back-to-back: next accept in the cycle after rsp_valid.
//  Store lanes: SB replicates wdata[7:0] to all lanes, wstrb=1<<addr[1:0];
//   SH replicates wdata[15:0], wstrb=addr[1]?1100:0011; SW wstrb=1111.
//  Load extract: byte at addr[1:0] (LB sign-, LBU zero-extend); half at addr[1]
//   (LH sign-, LHU zero-extend); LW passes the full word.
//  Reset mid-BUS aborts the request; no response is produced.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: 8-bit counter cleared on BUS entry, increments each BUS cycle
//   without bus_ready. When it reaches TIMEOUT_CYC: drop bus_valid -> ERR (rsp_err=1).
//  Undefined: no counter; BUS waits indefinitely.
// STRUCTURE
//  rv32_pkg: funct3 constants (F3_LB..F3_SW), LSU state encoding, XLEN=32.
//  Sub-module lsu_align (combinational): store lane steering/wstrb and load extract/extension.
// TESTING
//  SW x=0xDEADBEEF at 0x100, bus_ready=1 -> bus_wstrb=1111, bus_addr=0x100; rsp_valid T+2, rsp_wen=0.
//  LB from 0x103, bus_rdata=0x80000000 -> rsp_data=0xFFFFFF80, rsp_wen=1; LBU -> 0x00000080.
//  SH 0x1234 at 0x102 -> bus_wdata=0x12341234, bus_wstrb=1100.
//  LW at 0x102 -> rsp_err=1 at T+1, bus_valid never asserted, rsp_wen=0.
//  bus_ready held low 5 cycles -> bus fields stable, stall=1 throughout; response after ready.
//  rst_n low during BUS -> bus_valid=0 immediately, no rsp_valid; with LSU_TIMEOUT_EN, TIMEOUT_CYC=4,
//   no ready -> rsp_err=1.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the load/store path: funct3 encodings, LSU state encoding, XLEN.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and lane extract/extension for loads.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] st_data,
    output logic [3:0]      st_strb,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_data = wdata;
        st_strb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_data = {4{wdata[7:0]}};
                st_strb = 4'b0001 << addr_lo;
            end
            2'b01: begin
                st_data = {2{wdata[15:0]}};
                st_strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ld_data = {24'h0, byte_sel};
            F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ld_data = {16'h0, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32IM load/store unit: one request at a time onto a valid/ready word bus.
// Optional bus_ready timeout enabled by defining LSU_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | ready for a request from execute
//  BUS   | bus_valid high, waiting on bus_ready
//  DONE  | one-cycle good response
//  ERR   | one-cycle error response (illegal, misaligned, timeout)
module load_store_unit
   import rv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic        rsp_valid,
   output logic        rsp_wen,
   output logic [4:0]  rsp_rd,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        stall
);

   lsu_state_e      state_q, state_d;
   logic            load_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
   logic [4:0]      rd_q;
   logic            accept, illegal, misaligned;
   logic [XLEN-1:0] st_data, ld_data;
   logic [3:0]      st_strb;

   assign accept = (state_q == ST_IDLE) && req_valid && (mem_read || mem_write);

   always_comb begin
      illegal = 1'b0;
      if (mem_read && mem_write)
         illegal = 1'b1;
      else if (mem_read)
         illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      else
         illegal = (funct3 >= 3'b011);
   end

   assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] TC = 8'(TIMEOUT_CYC);
   logic [7:0] cnt_q;
   logic [7:0] cnt_inc;

   assign cnt_inc = cnt_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= 8'd0;
      else if (state_q != ST_BUS)
         cnt_q <= 8'd0;
      else if (!bus_ready)
         cnt_q <= cnt_inc;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         load_q  <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 5'd0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            load_q  <= mem_read;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            rd_q    <= rd;
            rdata_q <= '0;
         end else if (state_q == ST_BUS && bus_ready && load_q) begin
            rdata_q <= ld_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = (illegal || misaligned) ? ST_ERR : ST_BUS;
         ST_BUS: begin
            if (bus_ready)
               state_d = ST_DONE;
`ifdef LSU_TIMEOUT_EN
            else if (cnt_inc == TC)
               state_d = ST_ERR;
`endif
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   lsu_align u_align (
      .funct3  (f3_q),
      .addr_lo (addr_q[1:0]),
      .wdata   (wdata_q),
      .rdata   (bus_rdata),
      .st_data (st_data),
      .st_strb (st_strb),
      .ld_data (ld_data)
   );

   // Bus and response fields are forced to zero outside their active states.
   assign req_ready = (state_q == ST_IDLE);
   assign stall     = (state_q != ST_IDLE);
   assign bus_valid = (state_q == ST_BUS);
   assign bus_we    = bus_valid && !load_q;
   assign bus_addr  = bus_valid ? {addr_q[31:2], 2'b00} : '0;
   assign bus_wdata = (bus_valid && !load_q) ? st_data : '0;
   assign bus_wstrb = (bus_valid && !load_q) ? st_strb : 4'b0000;
   assign rsp_valid = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign rsp_err   = (state_q == ST_ERR);
   assign rsp_wen   = (state_q == ST_DONE) && load_q;
   assign rsp_rd    = rsp_valid ? rd_q : 5'd0;
   assign rsp_data  = rsp_wen ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests against a behavioural model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0, wdata = '0;
   logic [4:0]  rd = '0;
   logic        bus_ready = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        req_ready, bus_valid, bus_we, rsp_valid, rsp_wen, rsp_err, stall;
   logic [31:0] bus_addr, bus_wdata, rsp_data;
   logic [3:0]  bus_wstrb;
   logic [4:0]  rsp_rd;

   int n_checks = 0, n_errors = 0, rsp_seen = 0, rsp_exp = 0;

   logic        exp_err = 1'b0, exp_load = 1'b0, exp_timeout = 1'b0;
   logic [31:0] exp_addr = '0, exp_sdata = '0, exp_ld = '0;
   logic [3:0]  exp_strb = '0;
   logic [4:0]  exp_rd = '0;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 4;
`else
   localparam int unsigned TB_TIMEOUT = 255;
`endif

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
      .wdata(wdata), .rd(rd), .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata), .rsp_valid(rsp_valid),
      .rsp_wen(rsp_wen), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .stall(stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour written from the access rules: size, alignment, lane shifts.
   function automatic void model(input logic rd_, input logic wr_, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdat, output logic err,
                                 output logic [31:0] sdata, output logic [3:0] strb,
                                 output logic [31:0] ld);
      int sz, off;
      logic [31:0] mask, tmp;
      sz  = 1 << f3[1:0];
      off = int'(a[1:0]);
      err = rd_ && wr_;
      if (rd_ && !wr_) err = err || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (wr_ && !rd_) err = err || !(f3 inside {3'd0, 3'd1, 3'd2});
      if (!err && (off % sz) != 0) err = 1'b1;
      if (sz == 1)      sdata = 32'(wd[7:0]) * 32'h0101_0101;
      else if (sz == 2) sdata = 32'(wd[15:0]) * 32'h0001_0001;
      else              sdata = wd;
      tmp  = ((32'd1 << sz) - 32'd1) << off;
      strb = tmp[3:0];
      mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      ld   = (rdat >> (8 * off)) & mask;
      if (!f3[2] && sz < 4 && ld[8 * sz - 1]) ld = ld | ~mask;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("stall_vs_ready", {31'd0, stall}, {31'd0, !req_ready});
         if (bus_valid) begin
            chk("bus_on_error_req", {31'd0, exp_err}, 32'd0);
            chk("bus_addr", bus_addr, {exp_addr[31:2], 2'b00});
            chk("bus_we", {31'd0, bus_we}, {31'd0, !exp_load});
            chk("bus_wstrb", {28'd0, bus_wstrb}, exp_load ? 32'd0 : {28'd0, exp_strb});
            if (!exp_load) chk("bus_wdata", bus_wdata, exp_sdata);
         end
         if (rsp_valid) begin
            rsp_seen++;
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err | exp_timeout});
            chk("rsp_wen", {31'd0, rsp_wen}, {31'd0, exp_load & !(exp_err | exp_timeout)});
            chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, exp_rd});
            chk("rsp_data", rsp_data, (exp_load && !(exp_err | exp_timeout)) ? exp_ld : 32'd0);
         end
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (!req_ready && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("req_ready_before_req", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic issue(input logic rd_, input logic wr_, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                        input logic [31:0] rdat);
      wait_idle();
      model(rd_, wr_, f3, a, wd, rdat, exp_err, exp_sdata, exp_strb, exp_ld);
      exp_load = rd_ && !wr_;
      exp_addr = a;
      exp_rd   = r;
      req_valid = 1'b1; mem_read = rd_; mem_write = wr_;
      funct3 = f3; addr = a; wdata = wd; rd = r;
      @(negedge clk);
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      wdata = $urandom; addr = $urandom;
   endtask

   task automatic do_req(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                         input logic [31:0] rdat, input int delay);
      issue(rd_, wr_, f3, a, wd, r, rdat);
      rsp_exp++;
      if (exp_err) begin
         chk("err_rsp_at_t1", {31'd0, rsp_valid}, 32'd1);
         chk("err_no_bus", {31'd0, bus_valid}, 32'd0);
      end else begin
         chk("bus_valid_at_t1", {31'd0, bus_valid}, 32'd1);
         for (int i = 0; i < delay; i++) begin
            bus_rdata = $urandom;
            @(negedge clk);
            chk("wait_bus_valid", {31'd0, bus_valid}, 32'd1);
            chk("wait_stall", {31'd0, stall}, 32'd1);
            chk("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
         end
         bus_ready = 1'b1;
         bus_rdata = rdat;
         @(negedge clk);
         bus_ready = 1'b0;
         bus_rdata = $urandom;
         chk("rsp_after_ready", {31'd0, rsp_valid}, 32'd1);
      end
   endtask

   initial begin
      logic        m_err;
      logic [31:0] m_sd, m_ld;
      logic [3:0]  m_st;
      int          bv_cnt, waited;

      // Model pins against hand-computed values.
      model(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, m_err, m_sd, m_st, m_ld);
      chk("pin_sw_strb", {28'd0, m_st}, 32'hF);
      chk("pin_sw_data", m_sd, 32'hDEAD_BEEF);
      model(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, m_err, m_sd, m_st, m_ld);
      chk("pin_lb", m_ld, 32'hFFFF_FF80);
      model(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h8000_0000, m_err, m_sd, m_st, m_ld);
      chk("pin_lbu", m_ld, 32'h0000_0080);
      model(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234, 32'h0, m_err, m_sd, m_st, m_ld);
      chk("pin_sh_data", m_sd, 32'h1234_1234);
      chk("pin_sh_strb", {28'd0, m_st}, 32'hC);
      model(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, m_err, m_sd, m_st, m_ld);
      chk("pin_lw_misaligned", {31'd0, m_err}, 32'd1);

      #1;
      chk("reset_bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_rsp_data", rsp_data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd3, 32'h0, 0);
      do_req(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 32'h8000_0000, 0);
      chk("lb_literal", rsp_data, 32'hFFFF_FF80);
      do_req(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd6, 32'h8000_0000, 0);
      chk("lbu_literal", rsp_data, 32'h0000_0080);
      do_req(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234, 5'd0, 32'h0, 0);
      do_req(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd7, 32'h0, 0);
      chk("lw_mis_wen", {31'd0, rsp_wen}, 32'd0);
      do_req(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd8, 32'hCAFE_F00D, 5);
      chk("lw_delayed_literal", rsp_data, 32'hCAFE_F00D);
      do_req(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd9, 32'h8001_7FFF, 1);
      chk("lh_literal", rsp_data, 32'hFFFF_8001);
      do_req(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 5'd10, 32'h8001_7FFF, 0);
      chk("lhu_literal", rsp_data, 32'h0000_7FFF);
      do_req(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 5'd11, 32'h1234_5678, 2);
      do_req(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 5'd12, 32'h0, 0);
      do_req(1'b0, 1'b1, 3'b001, 32'h100, 32'h0000_BEEF, 5'd13, 32'h0, 0);
      do_req(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd14, 32'h0, 0);
      do_req(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd15, 32'h0, 0);
      do_req(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 5'd16, 32'h0, 0);
      do_req(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd17, 32'h0, 0);
      do_req(1'b0, 1'b1, 3'b001, 32'h103, 32'h0, 5'd18, 32'h0, 0);
      do_req(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 5'd19, 32'h0, 0);

      wait_idle();
      req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ignored_req_stall", {31'd0, stall}, 32'd0);
         chk("ignored_req_bus", {31'd0, bus_valid}, 32'd0);
      end
      req_valid = 1'b0;

      issue(1'b0, 1'b1, 3'b010, 32'h300, 32'h5555_AAAA, 5'd20, 32'h0);
      @(negedge clk);
      chk("pre_reset_bus_valid", {31'd0, bus_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

`ifdef LSU_TIMEOUT_EN
      issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd21, 32'h0);
      rsp_exp++;
      exp_timeout = 1'b1;
      bv_cnt = 0;
      waited = 0;
      while (!rsp_valid && waited < 20) begin
         if (bus_valid) bv_cnt++;
         @(negedge clk);
         waited++;
      end
      chk("timeout_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      chk("timeout_rsp_err", {31'd0, rsp_err}, 32'd1);
      chk("timeout_bus_cycles", 32'(bv_cnt), 32'd4);
      @(negedge clk);
      exp_timeout = 1'b0;
`else
      bv_cnt = 0;
      waited = 0;
`endif

      repeat (2) @(negedge clk);
      chk("rsp_count", 32'(rsp_seen), 32'(rsp_exp));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
